// File: rtl/lcd_pkg.sv
// Shared constants, busy-time defaults and FSM state type for the HD44780-style panel responder.
package lcd_pkg;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME_MASK = 8'hFE;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam int         SET_DDRAM_BIT = 7;

    localparam int DEF_BUSY_CYCLES      = 2000;
    localparam int DEF_BUSY_LONG_CYCLES = 82000;
    localparam int DEF_BUSY_W           = 17;
    localparam int DEF_SYNC_STAGES      = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        COMMIT = 2'd2
    } resp_state_t;

    // Clear and return-home both take the long execution time and zero the address counter.
    function automatic logic is_long_cmd(input logic [7:0] cmd);
        return (cmd == CMD_CLEAR) || ((cmd & CMD_HOME_MASK) == CMD_HOME);
    endfunction

endpackage

// File: rtl/lcd_sync.sv
// Multi-flop synchronizer for a bundle of asynchronous bus inputs (STAGES >= 2).
module lcd_sync #(
    parameter int WIDTH  = 7,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES*WIDTH-1:0] r_chain;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[(STAGES-1)*WIDTH-1:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/lcd_responder.sv
// Device-side HD44780 panel model: reassembles host nibbles, tracks AC and busy time, answers status reads.
// Optional LCD_RESPONDER_OVERRUN_EN adds a sticky 'overrun' output for bytes arriving while busy.
module lcd_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_CYCLES      = DEF_BUSY_CYCLES,
    parameter int BUSY_LONG_CYCLES = DEF_BUSY_LONG_CYCLES,
    parameter int BUSY_W           = DEF_BUSY_W,
    parameter int SYNC_STAGES      = DEF_SYNC_STAGES
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [3:0] LCD_D_IN,
    output logic [3:0] LCD_D_OUT,
    output logic       LCD_D_OE,
    input  logic       mode4bit,
    output logic [7:0] rx_byte,
    output logic       rx_rs,
    output logic       rx_valid,
    output logic       busy,
`ifdef LCD_RESPONDER_OVERRUN_EN
    output logic       overrun,
`endif
    output logic [6:0] addr_counter
);

    logic [6:0] w_sync;
    logic       w_e;
    logic       w_rs;
    logic       w_rw;
    logic [3:0] w_d;

    lcd_sync #(
        .WIDTH (7),
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk (CLK),
        .i_srst(RESET),
        .i_d   ({LCD_E, LCD_RS, LCD_RW, LCD_D_IN}),
        .o_q   (w_sync)
    );

    assign w_e  = w_sync[6];
    assign w_rs = w_sync[5];
    assign w_rw = w_sync[4];
    assign w_d  = w_sync[3:0];

    logic r_e_d;
    logic w_e_rise;
    logic w_e_fall;

    assign w_e_rise = w_e & ~r_e_d;
    assign w_e_fall = ~w_e & r_e_d;

    resp_state_t r_state;
    resp_state_t w_state_next;

    logic              r_rw_cap;
    logic              r_rs_cap;
    logic              r_last_dir;
    logic              r_phase;
    logic [3:0]        r_hi;
    logic [3:0]        r_d_lat;
    logic [3:0]        r_rd_nib;
    logic [6:0]        r_ac;
    logic [BUSY_W-1:0] r_busy_cnt;
    logic [7:0]        r_rx_byte;
    logic              r_rx_rs;
    logic              r_rx_valid;

    logic w_rise_accept;
    logic w_fall_write;
    logic w_commit;
    logic w_drive;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_e_rise) w_state_next = STROBE;
            STROBE:  if (w_e_fall) w_state_next = r_rw_cap ? IDLE : COMMIT;
            COMMIT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_rise_accept = (r_state == IDLE) && w_e_rise;
        w_fall_write  = (r_state == STROBE) && w_e_fall && !r_rw_cap;
        w_commit      = (r_state == COMMIT);
        w_drive       = (r_state == STROBE) && r_rw_cap;
    end

    // A pending high nibble only pairs with a nibble of the same direction; otherwise restart the pair.
    logic w_eff_phase;
    assign w_eff_phase = mode4bit & r_phase & (w_rw == r_last_dir);

    logic       w_byte_done;
    logic [7:0] w_byte;
    logic       w_phase_next;

    always_comb begin
        w_byte_done = 1'b0;
        w_byte      = {r_d_lat, 4'h0};
        if (w_commit) begin
            if (mode4bit && r_phase) begin
                w_byte_done = 1'b1;
                w_byte      = {r_hi, r_d_lat};
            end else if (!mode4bit) begin
                w_byte_done = 1'b1;
            end
        end
    end

    always_comb begin
        w_phase_next = r_phase;
        if (w_rise_accept) begin
            w_phase_next = w_rw ? (mode4bit & ~w_eff_phase) : w_eff_phase;
        end else if (w_commit && mode4bit) begin
            w_phase_next = ~r_phase;
        end
        if (!mode4bit) begin
            w_phase_next = 1'b0;
        end
    end

    logic [6:0]        w_ac_next;
    logic [BUSY_W-1:0] w_busy_load;

    always_comb begin
        w_ac_next   = r_ac;
        w_busy_load = BUSY_W'(BUSY_CYCLES);
        if (r_rs_cap) begin
            w_ac_next = r_ac + 7'd1;
        end else if (is_long_cmd(w_byte)) begin
            w_ac_next   = 7'd0;
            w_busy_load = BUSY_W'(BUSY_LONG_CYCLES);
        end else if (w_byte[SET_DDRAM_BIT]) begin
            w_ac_next = w_byte[6:0];
        end
    end

    logic [3:0] w_rd_nib;
    assign w_rd_nib = w_rs        ? 4'h0 :
                      w_eff_phase ? r_ac[3:0] : {busy, r_ac[6:4]};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_e_d      <= 1'b0;
            r_rw_cap   <= 1'b0;
            r_rs_cap   <= 1'b0;
            r_last_dir <= 1'b0;
            r_phase    <= 1'b0;
            r_hi       <= 4'h0;
            r_d_lat    <= 4'h0;
            r_rd_nib   <= 4'h0;
            r_ac       <= 7'd0;
            r_busy_cnt <= '0;
            r_rx_byte  <= 8'h00;
            r_rx_rs    <= 1'b0;
            r_rx_valid <= 1'b0;
        end else begin
            r_e_d      <= w_e;
            r_phase    <= w_phase_next;
            r_rx_valid <= w_byte_done;
            if (w_rise_accept) begin
                r_rw_cap   <= w_rw;
                r_rs_cap   <= w_rs;
                r_last_dir <= w_rw;
                r_rd_nib   <= w_rd_nib;
            end
            if (w_fall_write) begin
                r_d_lat <= w_d;
            end
            if (w_commit && mode4bit && !r_phase) begin
                r_hi <= r_d_lat;
            end
            if (w_byte_done) begin
                r_rx_byte  <= w_byte;
                r_rx_rs    <= r_rs_cap;
                r_ac       <= w_ac_next;
                r_busy_cnt <= w_busy_load;
            end else if (r_busy_cnt != '0) begin
                r_busy_cnt <= r_busy_cnt - BUSY_W'(1);
            end
        end
    end

`ifdef LCD_RESPONDER_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_overrun <= 1'b0;
        end else if (w_byte_done && busy) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;
`endif

    assign busy         = (r_busy_cnt != '0);
    assign addr_counter = r_ac;
    assign rx_byte      = r_rx_byte;
    assign rx_rs        = r_rx_rs;
    assign rx_valid     = r_rx_valid;
    assign LCD_D_OUT    = w_drive ? r_rd_nib : 4'h0;
    assign LCD_D_OE     = w_rw;

endmodule

// File: tb/tb_lcd_responder.sv
// Self-checking bench for lcd_responder: host nibble driver, spec-level panel model, randomized traffic.
module tb_lcd_responder;

    localparam int BC = 40;
    localparam int BL = 300;

    logic       clk;
    logic       RESET;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [3:0] LCD_D_IN;
    logic [3:0] LCD_D_OUT;
    logic       LCD_D_OE;
    logic       mode4bit;
    logic [7:0] rx_byte;
    logic       rx_rs;
    logic       rx_valid;
    logic       busy;
    logic [6:0] addr_counter;
`ifdef LCD_RESPONDER_OVERRUN_EN
    logic       overrun;
`endif

    lcd_responder #(
        .BUSY_CYCLES     (BC),
        .BUSY_LONG_CYCLES(BL),
        .BUSY_W          (17),
        .SYNC_STAGES     (2)
    ) dut (
        .CLK         (clk),
        .RESET       (RESET),
        .LCD_E       (LCD_E),
        .LCD_RS      (LCD_RS),
        .LCD_RW      (LCD_RW),
        .LCD_D_IN    (LCD_D_IN),
        .LCD_D_OUT   (LCD_D_OUT),
        .LCD_D_OE    (LCD_D_OE),
        .mode4bit    (mode4bit),
        .rx_byte     (rx_byte),
        .rx_rs       (rx_rs),
        .rx_valid    (rx_valid),
        .busy        (busy),
`ifdef LCD_RESPONDER_OVERRUN_EN
        .overrun     (overrun),
`endif
        .addr_counter(addr_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe / busy-edge monitor
    int         pulses = 0;
    logic [7:0] mon_byte = 8'h00;
    logic       mon_rs = 1'b0;
    int         mon_cyc = 0;
    int         busy_fall = 0;
    logic       prev_busy = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) begin
            pulses   <= pulses + 1;
            mon_byte <= rx_byte;
            mon_rs   <= rx_rs;
            mon_cyc  <= cyc;
        end
        if (!busy && prev_busy) busy_fall <= cyc;
        prev_busy <= busy;
    end

    // Reference panel model
    logic [6:0] m_ac = 7'd0;
    bit         m_phase = 1'b0;
    logic [3:0] m_hi = 4'h0;
    bit         m_dir = 1'b0;
    int         m_s = -1000000;
    int         m_len = 0;
    logic [3:0] last_rd = 4'h0;

    function automatic bit m_busy_at(input int c);
        return (c >= m_s) && (c < m_s + m_len);
    endfunction

    task automatic m_apply(input bit rs, input logic [7:0] b, input int s);
        m_s = s;
        m_len = BC;
        if (rs) m_ac = m_ac + 7'd1;
        else if (b == 8'h01 || b == 8'h02 || b == 8'h03) begin
            m_ac = 7'd0;
            m_len = BL;
        end else if (b >= 8'h80) m_ac = b[6:0];
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        RESET = 1'b1; LCD_E = 1'b0; LCD_RW = 1'b0;
        repeat (2) @(posedge clk);
        #1 RESET = 1'b0;
        m_ac = 7'd0; m_phase = 1'b0; m_dir = 1'b0; m_s = -1000000; m_len = 0;
    endtask

    task automatic set_mode(input bit m);
        @(posedge clk); #1;
        mode4bit = m;
        if (!m) m_phase = 1'b0;
    endtask

    // One host bus cycle (one nibble), checked against the model.
    task automatic nibble(input bit rs, input bit rw, input logic [3:0] d);
        int rise_k;
        int fall_edge;
        int exp_pulses;
        bit exp_strobe;
        logic [7:0] exp_byte;
        logic [3:0] exp_nib;
        exp_strobe = 1'b0;
        exp_byte = 8'h00;
        exp_nib = 4'h0;
        @(posedge clk); #1;
        LCD_RS = rs; LCD_RW = rw; LCD_D_IN = d;
        repeat (2) @(posedge clk);
        #1 LCD_E = 1'b1;
        rise_k = cyc;
        if (m_phase && (m_dir != rw)) m_phase = 1'b0;
        m_dir = rw;
        if (rw) begin
            exp_nib = rs ? 4'h0 : (m_phase ? m_ac[3:0] : {m_busy_at(rise_k + 2), m_ac[6:4]});
            m_phase = mode4bit ? !m_phase : 1'b0;
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        if (rw) begin
            last_rd = LCD_D_OUT;
            checks++;
            if (LCD_D_OUT !== exp_nib) begin
                errors++;
                $display("FAIL read_nibble: got %h expected %h (rs=%0d)", LCD_D_OUT, exp_nib, rs);
            end
            checks++;
            if (LCD_D_OE !== 1'b1) begin
                errors++;
                $display("FAIL oe_during_read: got %b expected 1", LCD_D_OE);
            end
        end
        @(posedge clk); #1;
        LCD_E = 1'b0;
        fall_edge = cyc + 1;
        exp_pulses = pulses;
        if (!rw) begin
            if (mode4bit) begin
                if (!m_phase) begin
                    m_hi = d;
                    m_phase = 1'b1;
                end else begin
                    exp_byte = {m_hi, d};
                    exp_strobe = 1'b1;
                    m_phase = 1'b0;
                end
            end else begin
                exp_byte = {d, 4'h0};
                exp_strobe = 1'b1;
            end
        end
        repeat (8) @(posedge clk);
        @(negedge clk);
        if (exp_strobe) begin
            m_apply(rs, exp_byte, fall_edge + 3);
            checks++;
            if (pulses !== exp_pulses + 1 || mon_byte !== exp_byte || mon_rs !== rs) begin
                errors++;
                $display("FAIL strobe: pulses=%0d byte=%h rs=%b expected pulses=%0d byte=%h rs=%b",
                         pulses - exp_pulses, mon_byte, mon_rs, 1, exp_byte, rs);
            end
            checks++;
            if (mon_cyc !== fall_edge + 3) begin
                errors++;
                $display("FAIL strobe_latency: got %0d expected %0d", mon_cyc - fall_edge, 3);
            end
            checks++;
            if (addr_counter !== m_ac) begin
                errors++;
                $display("FAIL addr_counter: got %h expected %h", addr_counter, m_ac);
            end
        end else begin
            checks++;
            if (pulses !== exp_pulses) begin
                errors++;
                $display("FAIL no_strobe: got %0d pulses expected 0", pulses - exp_pulses);
            end
        end
        if (rw) begin
            @(posedge clk); #1;
            LCD_RW = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            checks++;
            if (LCD_D_OE !== 1'b0) begin
                errors++;
                $display("FAIL oe_release: got %b expected 0", LCD_D_OE);
            end
        end
        $display("txn t=%0d mode4=%0d rs=%0d rw=%0d d=%h rd=%h strobe=%0d byte=%h ac=%h",
                 cyc, mode4bit, rs, rw, d, exp_nib, exp_strobe, exp_byte, addr_counter);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({rx_valid, rx_byte, rx_rs, busy, addr_counter, LCD_D_OUT, LCD_D_OE} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {rx_valid, rx_byte, rx_rs, busy, addr_counter, LCD_D_OUT, LCD_D_OE});
        end
    endtask

    task automatic test_8bit();
        set_mode(1'b0);
        nibble(1'b0, 1'b0, 4'h3);
        checks++;
        if (mon_byte !== 8'h30) begin
            errors++;
            $display("FAIL byte_8bit: got %h expected 30", mon_byte);
        end
        repeat (BC + 5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy_fall - mon_cyc !== BC) begin
            errors++;
            $display("FAIL busy_short: got %0d expected %0d", busy_fall - mon_cyc, BC);
        end
    endtask

    task automatic test_4bit();
        set_mode(1'b1);
        nibble(1'b0, 1'b0, 4'h8);
        nibble(1'b0, 1'b0, 4'h5);
        checks++;
        if (mon_byte !== 8'h85 || addr_counter !== 7'h05) begin
            errors++;
            $display("FAIL byte_4bit: got %h ac=%h expected 85 ac=05", mon_byte, addr_counter);
        end
        repeat (BC + 5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy_fall - mon_cyc !== BC) begin
            errors++;
            $display("FAIL busy_4bit: got %0d expected %0d", busy_fall - mon_cyc, BC);
        end
    endtask

    task automatic test_ac_wrap();
        logic [3:0] hi_rd;
        set_mode(1'b1);
        nibble(1'b0, 1'b0, 4'hF);
        nibble(1'b0, 1'b0, 4'hF);
        nibble(1'b1, 1'b0, 4'h4);
        nibble(1'b1, 1'b0, 4'h1);
        checks++;
        if (addr_counter !== 7'h00) begin
            errors++;
            $display("FAIL ac_wrap: got %h expected 00", addr_counter);
        end
        nibble(1'b0, 1'b1, 4'h0);
        hi_rd = last_rd;
        nibble(1'b0, 1'b1, 4'h0);
        checks++;
        if (hi_rd !== 4'h8 || last_rd !== 4'h0) begin
            errors++;
            $display("FAIL status_after_wrap: got %h,%h expected 8,0", hi_rd, last_rd);
        end
    endtask

    task automatic test_clear_poll();
        int polls;
        int clr_cyc;
        bit done;
        set_mode(1'b1);
        nibble(1'b0, 1'b0, 4'h0);
        nibble(1'b0, 1'b0, 4'h1);
        clr_cyc = mon_cyc;
        done = 1'b0;
        polls = 0;
        while (!done && polls < 50) begin
            nibble(1'b0, 1'b1, 4'h0);
            done = !last_rd[3];
            nibble(1'b0, 1'b1, 4'h0);
            polls++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL clear_poll_timeout: got %0d polls expected BF=0", polls);
        end
        checks++;
        if (busy_fall - clr_cyc !== BL) begin
            errors++;
            $display("FAIL busy_long: got %0d expected %0d", busy_fall - clr_cyc, BL);
        end
        nibble(1'b1, 1'b0, 4'h4);
        nibble(1'b1, 1'b0, 4'h8);
    endtask

    task automatic test_reset_mid();
        int p;
        set_mode(1'b1);
        nibble(1'b0, 1'b0, 4'h2);
        p = pulses;
        do_reset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pulses !== p || addr_counter !== 7'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got pulses=%0d ac=%h busy=%b expected 0,00,0",
                     pulses - p, addr_counter, busy);
        end
        nibble(1'b0, 1'b0, 4'h2);
        nibble(1'b0, 1'b0, 4'h8);
        checks++;
        if (mon_byte !== 8'h28) begin
            errors++;
            $display("FAIL after_reset_byte: got %h expected 28", mon_byte);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(9) == 0) set_mode(!mode4bit);
            else nibble(1'($urandom_range(1)), ($urandom_range(2) == 0), 4'($urandom_range(15)));
            repeat ($urandom_range(30)) @(posedge clk);
        end
    endtask

`ifdef LCD_RESPONDER_OVERRUN_EN
    task automatic test_overrun();
        do_reset();
        set_mode(1'b0);
        nibble(1'b0, 1'b0, 4'h2);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_first: got %b expected 0", overrun);
        end
        nibble(1'b0, 1'b0, 4'h2);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b expected 1", overrun);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b expected 0", overrun);
        end
    endtask
`endif

    initial begin
        RESET = 1'b1;
        LCD_E = 1'b0;
        LCD_RS = 1'b0;
        LCD_RW = 1'b0;
        LCD_D_IN = 4'h0;
        mode4bit = 1'b0;
        test_reset();
        test_8bit();
        test_4bit();
        test_ac_wrap();
        test_clear_poll();
        test_reset_mid();
        test_random();
`ifdef LCD_RESPONDER_OVERRUN_EN
        test_overrun();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
